virtual_pe_nway: RTL and testbench
==================================

# virtual_pe_nway

Parametrised virtual PE for deadlock checking of the cast/merge network. It emulates only the data dependencies of a real PE: it buffers cast input flits, collects one packet, waits a configurable compute latency, then emits the packet. A non-caster emits on its merge output. A caster joins the packet with MERGE_N merge-input streams and casts the per-flit sum, prefixed by a stream-id header flit. It sits at every mesh node between the cast and merge router ports, in place of a behavioural PE.

## Interface
- DW, 32, flit width.
- MERGE_N, 2, number of merge input channels; must be at least 1.
- FIFO_DEPTH, 4, depth of the cast receive FIFO.
- FIFO_DEPTH_LOG, 2, log2(FIFO_DEPTH).
- PKT_LEN, 4, data flits per packet; must be at least 1.
- PE_LAT, 2, emulated compute latency in cycles; 0 allowed.
- IS_CASTER, 0, 1 means the node joins merge inputs and drives the cast output.
- STREAM_ID, 10'd0, 10-bit stream id carried in the caster header flit.
- WD_CYCLES, 1024, watchdog threshold in cycles.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock, synchronous, active-low.
- valid_i_cast / data_i_cast / ready_o_cast  in/in/out  1/DW/1  cast input.
- valid_o_cast / data_o_cast / ready_i_cast  out/out/in  1/DW/1  cast output.
- valid_i_merge / data_i_merge / ready_o_merge  in/in/out  MERGE_N / MERGE_N*DW / MERGE_N  merge inputs; channel n occupies data bits [n*DW +: DW].
- valid_o_merge / data_o_merge / ready_i_merge  out/out/in  1/DW/1  merge output.
- stall_o  out  1  sticky watchdog flag.

## Operation
- **Cast receive FIFO**
  - First-word-fall-through, FIFO_DEPTH entries.
  - Write when valid_i_cast & ready_o_cast; ready_o_cast = ~full.
  - A write into an empty FIFO becomes visible at the head the next cycle; there is no bypass.
  - When full, no write is accepted, even in a cycle that also pops.
- **Engine FSM.** States LOAD, WAIT, HEAD, EMIT; reset state is LOAD. A flit counter cnt runs 0..PKT_LEN-1.
  - LOAD: each cycle the FIFO is non-empty, pop the head into pkt_buf[cnt]. On the pop with cnt=PKT_LEN-1, clear cnt and go to WAIT (or straight to the post-WAIT state if PE_LAT=0).
  - WAIT: stay exactly PE_LAT cycles, then go to HEAD if IS_CASTER, else EMIT.
  - HEAD (caster only): valid_o_cast=1, data_o_cast = {zeros, STREAM_ID}. Go to EMIT when ready_i_cast=1.
  - EMIT, non-caster: valid_o_merge=1, data_o_merge=pkt_buf[cnt]. A flit advances on ready_i_merge.
  - EMIT, caster: valid_o_cast = &valid_i_merge. data_o_cast = pkt_buf[cnt] + sum of all merge channel flits, computed mod 2^DW. A flit advances when &valid_i_merge & ready_i_cast.
  - EMIT exit: when the last flit is accepted, clear cnt and return to LOAD.
- **Merge input join (caster).** All ready_o_merge bits are asserted together, only in the advance cycle. There is no partial consumption: any invalid channel stalls all channels.
- **Unused outputs.**
  - Non-caster: ready_o_merge=0, valid_o_cast=0.
  - Caster: valid_o_merge=0.
- **Overlap.** The FIFO keeps accepting flits during WAIT, HEAD and EMIT. It is popped only in LOAD.

## Timing
- **Reset.** While rstn=0 at a clock edge: FIFO cleared, cnt=0, state=LOAD, stall_o=0. From the following cycle, all valid outputs are 0, all data outputs are 0, ready_o_merge=0, and ready_o_cast=1. Reset mid-packet discards all buffered and partial data.
- **Latency, non-caster, flits already in FIFO.** The first merge-out flit is valid PKT_LEN+PE_LAT cycles after the first pop.
- **Latency, caster.** Header valid PKT_LEN+PE_LAT cycles after the first pop; data flits follow.
- **Throughput.** One flit per cycle in LOAD and EMIT.
- **Handshake rules.** Outputs are valid/ready handshaked. valid_o_* and data_o_* hold stable until accepted, except when caster EMIT valid drops because a merge input withdraws.

## Configuration
- VPE_DEADLOCK_WD_EN
  - Defined: a counter increments each cycle the state is not LOAD and no flit advances, or the state is LOAD with the FIFO empty and a packet partially loaded (cnt>0). Any advance clears the counter. When the counter reaches WD_CYCLES, stall_o is set and stays set until reset.
  - Not defined: stall_o is tied to 0 and no counter logic is generated.

## Test plan
- **Non-caster basic** (PKT_LEN=4, PE_LAT=2): push 1,2,3,4 back-to-back, ready_i_merge=1 -> merge out 1,2,3,4 on consecutive cycles, first valid 6 cycles after the first pop; valid_o_cast stays 0.
- **Caster join** (STREAM_ID=0x2A): cast in 1,2,3,4; merge0 = 10,20,30,40; merge1 = 100,200,300,400 -> cast out 0x0000002A, 111, 222, 333, 444.
- **Join stall:** caster in EMIT, merge1 valid held 0 for 5 cycles -> valid_o_cast=0 and ready_o_merge=2'b00 for those 5 cycles; merge0 flit 10 not consumed.
- **FIFO full:** non-caster held in EMIT with ready_i_merge=0, push 5 flits -> 4 accepted, ready_o_cast=0 from the cycle after the 4th write, 5th flit held until EMIT completes and LOAD pops.
- **Wrap:** caster with pkt flit 0xFFFFFFFF and merge flits 1, 1 -> data_o_cast = 0x00000001.
- **Reset and watchdog:**
  - rstn=0 for one edge mid-EMIT -> next cycle all valids 0, ready_o_cast=1, state LOAD.
  - With VPE_DEADLOCK_WD_EN and WD_CYCLES=16, hold ready_i_merge=0 in EMIT -> stall_o rises after 16 stalled cycles and stays high.

Source files
------------

// File: rtl/virtual_pe_nway.sv
// Virtual PE: buffers one cast packet, waits PE_LAT cycles, then emits it (non-caster)
// or joins it with MERGE_N merge streams behind a stream-id header (caster). Optional watchdog: VPE_DEADLOCK_WD_EN.
module virtual_pe_nway #(
    parameter int DW             = 32,
    parameter int MERGE_N        = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_DEPTH_LOG = 2,
    parameter int PKT_LEN        = 4,
    parameter int PE_LAT         = 2,
    parameter int IS_CASTER      = 0,
    parameter logic [9:0] STREAM_ID = 10'd0,
    parameter int WD_CYCLES      = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid_i_cast,
    input  logic [DW-1:0]         data_i_cast,
    output logic                  ready_o_cast,
    output logic                  valid_o_cast,
    output logic [DW-1:0]         data_o_cast,
    input  logic                  ready_i_cast,
    input  logic [MERGE_N-1:0]    valid_i_merge,
    input  logic [MERGE_N*DW-1:0] data_i_merge,
    output logic [MERGE_N-1:0]    ready_o_merge,
    output logic                  valid_o_merge,
    output logic [DW-1:0]         data_o_merge,
    input  logic                  ready_i_merge,
    output logic                  stall_o
);
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int LW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [FIFO_DEPTH_LOG:0] FULL_CNT = FIFO_DEPTH[FIFO_DEPTH_LOG:0];
    localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(PE_LAT - 1);

    typedef enum logic [1:0] {LOAD, WAIT, HEAD, EMIT} state_t;

    state_t                  state;
    state_t                  post_wait;
    logic [CW-1:0]           cnt;
    logic [LW-1:0]           wcnt;
    logic [DW-1:0]           fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG:0] count;
    logic [DW-1:0]           pkt_buf [PKT_LEN];
    logic                    full, empty, wr_en, pop;
    logic                    all_valid, head_acc, emit_acc;
    logic [DW-1:0]           merge_sum;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign ready_o_cast = ~full;
    assign wr_en        = valid_i_cast & ~full;
    assign pop          = (state == LOAD) & ~empty;
    assign all_valid    = &valid_i_merge;
    assign post_wait    = (IS_CASTER != 0) ? HEAD : EMIT;
    assign head_acc     = (state == HEAD) & ready_i_cast;
    assign emit_acc     = (state == EMIT) &
                          ((IS_CASTER != 0) ? (all_valid & ready_i_cast) : ready_i_merge);

    // Storage is not reset; reset only clears pointers and the packet counter.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr] <= data_i_cast;
        if (pop)   pkt_buf[cnt] <= fifo_mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= LOAD;
            cnt   <= '0;
            wcnt  <= '0;
        end else begin
            case (state)
                LOAD: if (pop) begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        wcnt  <= '0;
                        state <= (PE_LAT == 0) ? post_wait : WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: if (wcnt == LAST_LAT) begin
                    wcnt  <= '0;
                    state <= post_wait;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                HEAD: if (ready_i_cast) state <= EMIT;
                EMIT: if (emit_acc) begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_comb begin
        merge_sum = pkt_buf[cnt];
        for (int n = 0; n < MERGE_N; n++) merge_sum = merge_sum + data_i_merge[n*DW +: DW];
    end

    always_comb begin
        valid_o_cast  = 1'b0;
        data_o_cast   = '0;
        valid_o_merge = 1'b0;
        data_o_merge  = '0;
        ready_o_merge = '0;
        if (IS_CASTER != 0) begin
            if (state == HEAD) begin
                valid_o_cast = 1'b1;
                data_o_cast  = DW'(STREAM_ID);
            end else if (state == EMIT) begin
                valid_o_cast  = all_valid;
                data_o_cast   = merge_sum;
                ready_o_merge = {MERGE_N{emit_acc}};
            end
        end else if (state == EMIT) begin
            valid_o_merge = 1'b1;
            data_o_merge  = pkt_buf[cnt];
        end
    end

`ifdef VPE_DEADLOCK_WD_EN
    localparam int WW = $clog2(WD_CYCLES + 1);
    localparam logic [WW-1:0] WD_T = WW'(WD_CYCLES);
    logic [WW-1:0] wd_cnt;
    logic          wd_inc, stall;

    // WAIT counts as a stall: nothing advances there either.
    assign wd_inc = ((state != LOAD) & ~(head_acc | emit_acc)) |
                    ((state == LOAD) & empty & (cnt != '0));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_cnt <= '0;
            stall  <= 1'b0;
        end else if (wd_inc) begin
            if (wd_cnt != WD_T)         wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_T - 1'b1)  stall  <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
    assign stall_o = stall;
`else
    assign stall_o = 1'b0;
`endif
endmodule

// File: tb/tb_virtual_pe_nway.sv
// Bench for virtual_pe_nway: one non-caster and one caster instance against queue-based models.
module tb_virtual_pe_nway;
    localparam int PL  = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        nc_vic, nc_roc, nc_voc, nc_ric, nc_vom, nc_rim, nc_stall;
    logic [31:0] nc_dic, nc_doc, nc_dom;
    logic [1:0]  nc_vim, nc_rom;
    logic [63:0] nc_dim;
    logic        c_vic, c_roc, c_voc, c_ric, c_vom, c_rim, c_stall;
    logic [31:0] c_dic, c_doc, c_dom;
    logic [1:0]  c_vim, c_rom;
    logic [63:0] c_dim;

    virtual_pe_nway #(.DW(32), .MERGE_N(2), .FIFO_DEPTH(4), .FIFO_DEPTH_LOG(2), .PKT_LEN(PL),
                      .PE_LAT(LAT), .IS_CASTER(0), .STREAM_ID(10'h2A), .WD_CYCLES(16)) u_nc (
        .clk(clk), .rstn(rstn),
        .valid_i_cast(nc_vic), .data_i_cast(nc_dic), .ready_o_cast(nc_roc),
        .valid_o_cast(nc_voc), .data_o_cast(nc_doc), .ready_i_cast(nc_ric),
        .valid_i_merge(nc_vim), .data_i_merge(nc_dim), .ready_o_merge(nc_rom),
        .valid_o_merge(nc_vom), .data_o_merge(nc_dom), .ready_i_merge(nc_rim),
        .stall_o(nc_stall));

    virtual_pe_nway #(.DW(32), .MERGE_N(2), .FIFO_DEPTH(4), .FIFO_DEPTH_LOG(2), .PKT_LEN(PL),
                      .PE_LAT(LAT), .IS_CASTER(1), .STREAM_ID(10'h2A), .WD_CYCLES(16)) u_c (
        .clk(clk), .rstn(rstn),
        .valid_i_cast(c_vic), .data_i_cast(c_dic), .ready_o_cast(c_roc),
        .valid_o_cast(c_voc), .data_o_cast(c_doc), .ready_i_cast(c_ric),
        .valid_i_merge(c_vim), .data_i_merge(c_dim), .ready_o_merge(c_rom),
        .valid_o_merge(c_vom), .data_o_merge(c_dom), .ready_i_merge(c_rim),
        .stall_o(c_stall));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] nc_in_q[$], nc_exp_q[$];
    logic [31:0] c_in_q[$], c_m0_q[$], c_m1_q[$], c_exp_q[$];
    bit          c_hdr_q[$];
    bit          nc_wr_ev, nc_out_ev, nc_hold;
    logic [31:0] nc_hold_d;
    bit          c_wr_ev, c_out_ev, c_hdr_ev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic nc_add_pkt(input int mode);
        for (int i = 0; i < PL; i++) nc_in_q.push_back(mode == 1 ? 32'(i + 1) : $urandom);
    endtask

    // mode 1: directed join values, mode 2: wrap-around first flit, else random.
    task automatic c_add_pkt(input int mode);
        logic [31:0] a, b, m, e;
        c_exp_q.push_back(32'h0000_002A);
        c_hdr_q.push_back(1'b1);
        for (int i = 0; i < PL; i++) begin
            a = $urandom; b = $urandom; m = $urandom; e = a + b + m;
            if (mode == 1) begin
                a = 32'(i + 1); b = 32'(10 * (i + 1)); m = 32'(100 * (i + 1)); e = 32'(111 * (i + 1));
            end else if (mode == 2 && i == 0) begin
                a = 32'hFFFF_FFFF; b = 32'd1; m = 32'd1; e = 32'd1;
            end
            c_in_q.push_back(a); c_m0_q.push_back(b); c_m1_q.push_back(m);
            c_exp_q.push_back(e); c_hdr_q.push_back(1'b0);
        end
    endtask

    task automatic nc_step(input bit push, input bit rdy);
        @(posedge clk); #1;
        nc_vic = push && (nc_in_q.size() > 0);
        nc_dic = nc_vic ? nc_in_q[0] : $urandom;
        nc_rim = rdy;
        nc_ric = 1'b1;
        nc_vim = 2'($urandom_range(0, 3));
        nc_dim = {$urandom, $urandom};
        #1;
        nc_wr_ev  = nc_vic && nc_roc;
        nc_out_ev = nc_vom && rdy;
        check_eq("nc_valid_o_cast", nc_voc, 0);
        check_eq("nc_ready_o_merge", nc_rom, 0);
        if (nc_hold) begin
            check_eq("nc_hold_valid", nc_vom, 1);
            check_eq("nc_hold_data", nc_dom, nc_hold_d);
        end
        if (nc_out_ev) begin
            if (nc_exp_q.size() == 0) check_eq("nc_unexpected_out", nc_dom, 32'hDEAD_BEEF ^ nc_dom);
            else check_eq("nc_data", nc_dom, nc_exp_q.pop_front());
        end
        nc_hold   = nc_vom && !rdy;
        nc_hold_d = nc_dom;
        if (nc_wr_ev) nc_exp_q.push_back(nc_in_q.pop_front());
        cyc++;
    endtask

    task automatic c_step(input bit push, input bit rdy, input bit m0, input bit m1);
        bit v0, v1, front_data;
        @(posedge clk); #1;
        c_vic = push && (c_in_q.size() > 0);
        c_dic = c_vic ? c_in_q[0] : $urandom;
        c_ric = rdy;
        c_rim = 1'($urandom_range(0, 1));
        v0 = m0 && (c_m0_q.size() > 0);
        v1 = m1 && (c_m1_q.size() > 0);
        c_vim = {v1, v0};
        c_dim = {v1 ? c_m1_q[0] : $urandom, v0 ? c_m0_q[0] : $urandom};
        #1;
        front_data = (c_hdr_q.size() > 0) && !c_hdr_q[0];
        c_wr_ev  = c_vic && c_roc;
        c_out_ev = c_voc && rdy;
        c_hdr_ev = 1'b0;
        check_eq("c_valid_o_merge", c_vom, 0);
        if (!(v0 && v1) && front_data) check_eq("c_join_valid", c_voc, 0);
        check_eq("c_ready_o_merge", c_rom, (c_out_ev && front_data) ? 2'b11 : 2'b00);
        if (c_out_ev) begin
            if (c_exp_q.size() == 0) check_eq("c_unexpected_out", c_doc, 32'hDEAD_BEEF ^ c_doc);
            else begin
                check_eq(front_data ? "c_data" : "c_header", c_doc, c_exp_q.pop_front());
                if (c_hdr_q.pop_front()) c_hdr_ev = 1'b1;
                else begin
                    void'(c_m0_q.pop_front());
                    void'(c_m1_q.pop_front());
                end
            end
        end
        if (c_wr_ev) void'(c_in_q.pop_front());
        cyc++;
    endtask

    task automatic nc_idle();
        @(posedge clk); #1;
        nc_vic = 1'b0; nc_rim = 1'b0; nc_hold = 1'b0;
    endtask

    task automatic c_idle();
        @(posedge clk); #1;
        c_vic = 1'b0; c_vim = 2'b00; c_ric = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        nc_vic = 1'b0; nc_dic = '0; nc_ric = 1'b0; nc_vim = '0; nc_dim = '0; nc_rim = 1'b0;
        c_vic = 1'b0; c_dic = '0; c_ric = 1'b0; c_vim = '0; c_dim = '0; c_rim = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        nc_in_q.delete(); nc_exp_q.delete(); nc_hold = 1'b0;
        c_in_q.delete(); c_m0_q.delete(); c_m1_q.delete(); c_exp_q.delete(); c_hdr_q.delete();
        check_eq("rst_nc_valid_o_cast", nc_voc, 0);
        check_eq("rst_nc_valid_o_merge", nc_vom, 0);
        check_eq("rst_nc_data_o_merge", nc_dom, 0);
        check_eq("rst_nc_data_o_cast", nc_doc, 0);
        check_eq("rst_nc_ready_o_merge", nc_rom, 0);
        check_eq("rst_nc_ready_o_cast", nc_roc, 1);
        check_eq("rst_nc_stall", nc_stall, 0);
        check_eq("rst_c_valid_o_cast", c_voc, 0);
        check_eq("rst_c_valid_o_merge", c_vom, 0);
        check_eq("rst_c_data_o_cast", c_doc, 0);
        check_eq("rst_c_data_o_merge", c_dom, 0);
        check_eq("rst_c_ready_o_merge", c_rom, 0);
        check_eq("rst_c_ready_o_cast", c_roc, 1);
        check_eq("rst_c_stall", c_stall, 0);
    endtask

    // Back-to-back directed packet; first pop is one cycle after the first write.
    task automatic nc_basic(input string tag);
        int fw, fv, lv;
        fw = -1; fv = -1; lv = -1;
        nc_add_pkt(1);
        for (int k = 0; k < 40 && (nc_in_q.size() > 0 || nc_exp_q.size() > 0 || fv < 0); k++) begin
            nc_step(1'b1, 1'b1);
            if (nc_wr_ev && fw < 0) fw = cyc;
            if (nc_out_ev) begin
                if (fv < 0) fv = cyc;
                lv = cyc;
            end
        end
        nc_idle();
        check_eq({tag, "_drained"}, 32'(nc_in_q.size() + nc_exp_q.size()), 0);
        check_eq({tag, "_latency"}, 32'(fv - fw), 32'(1 + PL + LAT));
        check_eq({tag, "_burst"}, 32'(lv - fv), 32'(PL - 1));
    endtask

    task automatic nc_drain(input string tag, input int pct_push, input int pct_rdy);
        for (int k = 0; k < 1000 && (nc_in_q.size() > 0 || nc_exp_q.size() > 0); k++)
            nc_step($urandom_range(0, 99) < pct_push, $urandom_range(0, 99) < pct_rdy);
        nc_idle();
        check_eq({tag, "_drained"}, 32'(nc_in_q.size() + nc_exp_q.size()), 0);
    endtask

    task automatic c_drain(input string tag, input int pp, input int pr, input int pm);
        for (int k = 0; k < 1500 && c_exp_q.size() > 0; k++)
            c_step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pr,
                   $urandom_range(0, 99) < pm, $urandom_range(0, 99) < pm);
        c_idle();
        check_eq({tag, "_drained"}, 32'(c_exp_q.size()), 0);
    endtask

    task automatic c_until_header(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            c_step(1'b1, 1'b1, 1'b1, 1'b1);
            seen = c_hdr_ev;
        end
        check_eq({tag, "_header_seen"}, seen, 1);
    endtask

    initial begin
        int fw, fh, lo, wr, fv;
        bit exp_stall;

        do_reset();

        nc_basic("nc_basic");

        // FIFO full: hold the non-caster in EMIT, then offer five flits.
        nc_add_pkt(0); nc_add_pkt(0); nc_add_pkt(0);
        wr = 0; fv = -1;
        for (int k = 0; k < 30 && fv < 0; k++) begin
            nc_step(wr < PL, 1'b0);
            if (nc_wr_ev) wr++;
            if (nc_vom) fv = cyc;
        end
        check_eq("full_reach_emit", fv >= 0, 1);
        for (int j = 0; j < 8; j++) begin
            nc_step(1'b1, 1'b0);
            check_eq("full_ready_o_cast", nc_roc, j < 4 ? 1 : 0);
            check_eq("full_write", nc_wr_ev, j < 4 ? 1 : 0);
        end
        nc_drain("full", 100, 100);

        for (int p = 0; p < 6; p++) nc_add_pkt(0);
        nc_drain("nc_rand", 70, 60);

        // Caster directed join with latency and burst timing.
        c_add_pkt(1);
        fw = -1; fh = -1; lo = -1;
        for (int k = 0; k < 40 && c_exp_q.size() > 0; k++) begin
            c_step(1'b1, 1'b1, 1'b1, 1'b1);
            if (c_wr_ev && fw < 0) fw = cyc;
            if (c_hdr_ev && fh < 0) fh = cyc;
            if (c_out_ev) lo = cyc;
        end
        c_idle();
        check_eq("c_join_drained", 32'(c_exp_q.size()), 0);
        check_eq("c_header_latency", 32'(fh - fw), 32'(1 + PL + LAT));
        check_eq("c_data_burst", 32'(lo - fh), 32'(PL));

        // Wrap-around sum, with merge1 withheld for five EMIT cycles.
        c_add_pkt(2);
        c_until_header("stall");
        for (int j = 0; j < 5; j++) begin
            c_step(1'b1, 1'b1, 1'b1, 1'b0);
            check_eq("stall_valid_o_cast", c_voc, 0);
            check_eq("stall_ready_o_merge", c_rom, 2'b00);
        end
        check_eq("stall_m0_kept", 32'(c_m0_q.size()), 32'(PL));
        c_drain("wrap", 100, 100, 100);

        for (int p = 0; p < 5; p++) c_add_pkt(0);
        c_drain("c_rand", 70, 70, 80);

        // Reset with both instances mid-packet, then confirm LOAD by timing.
        nc_add_pkt(0);
        wr = 0; fv = -1;
        for (int k = 0; k < 30 && fv < 0; k++) begin
            nc_step(wr < PL, 1'b0);
            if (nc_wr_ev) wr++;
            if (nc_vom) fv = cyc;
        end
        nc_idle();
        c_add_pkt(0);
        c_until_header("midrst");
        c_idle();
        do_reset();
        nc_basic("post_rst");

        // Watchdog: stalled cycles start with WAIT, two cycles before the first valid.
        do_reset();
        nc_add_pkt(0);
        wr = 0; fv = -1;
        for (int k = 0; k < 30 && fv < 0; k++) begin
            nc_step(wr < PL, 1'b0);
            if (nc_wr_ev) wr++;
            if (nc_vom) fv = cyc;
        end
        check_eq("wd_reach_emit", fv >= 0, 1);
        for (int j = 1; j <= 20; j++) begin
            nc_step(1'b0, 1'b0);
`ifdef VPE_DEADLOCK_WD_EN
            exp_stall = (j >= 16 - LAT);
`else
            exp_stall = 1'b0;
`endif
            check_eq("wd_stall", nc_stall, exp_stall);
        end
        nc_drain("wd", 100, 100);
        check_eq("wd_sticky", nc_stall, exp_stall);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
